// File: rtl/fpu_add_sub_pipe.sv
// fpu_add_sub_pipe: four-stage pipelined IEEE-754 adder/subtractor.
//   S1 unpack/swap, S2 align, S3 add, S4 normalize/round/pack (output regs).
// Ports:
//   I_Clk, I_Reset          clock, asynchronous active-high reset
//   I_Valid / O_Ready       input handshake (O_Ready combinational)
//   I_Op1, I_Op2, I_Sub     packed operands, 1 = subtract
//   I_Tag / O_Tag           opaque tag carried with each operation
//   O_Valid / I_Ready       output handshake
//   O_Result                packed, rounded result
//   O_Overflow, O_Underflow, O_Inexact, O_Invalid  status flags
// Configuration macro: FPU_ADDSUB_RNE_EN selects round-to-nearest-even;
// when undefined the datapath truncates and overflow saturates to max finite.
module fpu_add_sub_pipe #(
  parameter int unsigned PRECISION = 32,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 I_Clk,
  input  logic                 I_Reset,
  input  logic                 I_Valid,
  output logic                 O_Ready,
  input  logic [PRECISION-1:0] I_Op1,
  input  logic [PRECISION-1:0] I_Op2,
  input  logic                 I_Sub,
  input  logic [TAG_WIDTH-1:0] I_Tag,
  output logic                 O_Valid,
  input  logic                 I_Ready,
  output logic [PRECISION-1:0] O_Result,
  output logic [TAG_WIDTH-1:0] O_Tag,
  output logic                 O_Overflow,
  output logic                 O_Underflow,
  output logic                 O_Inexact,
  output logic                 O_Invalid
);

  localparam int unsigned EW = (PRECISION == 64) ? 11 : 8;
  localparam int unsigned MW = (PRECISION == 64) ? 52 : 23;
  localparam int unsigned FW = MW + 4;   // hidden + fraction + G/R/S
  localparam int unsigned SW = MW + 5;   // FW plus carry
  localparam int unsigned RW = MW + 2;   // rounded mantissa plus carry-out
  localparam int unsigned XW = EW + 2;   // signed working exponent
  localparam int unsigned LW = $clog2(FW + 1);
  localparam logic [EW-1:0] EXP_ONES = '1;

  // Per-operation control carried alongside the datapath
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 sign;      // sign of the larger-magnitude operand
    logic                 nan;       // result is canonical quiet NaN
    logic                 inf;       // result is infinity
    logic                 inf_sign;
    logic                 zneg;      // both operands zero and negative
  } ctl_t;

  logic stall;

  // Pipeline registers
  logic          s1_valid, s2_valid, s3_valid;
  ctl_t          s1_ctl, s2_ctl, s3_ctl;
  logic          s1_eff_sub, s2_eff_sub;
  logic [EW-1:0] s1_exp_a, s1_exp_b, s2_exp_a, s3_exp;
  logic [MW:0]   s1_man_a, s1_man_b;
  logic [FW-1:0] s2_man_a, s2_man_b;
  logic [SW-1:0] s3_sum;

  // Global all-or-nothing backpressure
  assign stall   = O_Valid & ~I_Ready;
  assign O_Ready = ~stall;

  // S1: unpack, flush denormals, classify specials, order by magnitude
  logic          sgn1, sgn2, zero1, zero2, nan1, nan2, inf1, inf2, swap;
  logic [EW-1:0] exp1, exp2;
  logic [MW-1:0] frc1, frc2;
  logic [MW:0]   man1, man2;
  ctl_t          ctl_in;

  always_comb begin
    sgn1  = I_Op1[PRECISION-1];
    sgn2  = I_Op2[PRECISION-1] ^ I_Sub;
    exp1  = I_Op1[PRECISION-2:MW];
    exp2  = I_Op2[PRECISION-2:MW];
    frc1  = I_Op1[MW-1:0];
    frc2  = I_Op2[MW-1:0];
    zero1 = (exp1 == '0);
    zero2 = (exp2 == '0);
    nan1  = (exp1 == EXP_ONES) && (frc1 != '0);
    nan2  = (exp2 == EXP_ONES) && (frc2 != '0);
    inf1  = (exp1 == EXP_ONES) && (frc1 == '0);
    inf2  = (exp2 == EXP_ONES) && (frc2 == '0);
    man1  = zero1 ? '0 : {1'b1, frc1};
    man2  = zero2 ? '0 : {1'b1, frc2};
    swap  = {exp2, man2} > {exp1, man1};

    ctl_in.tag      = I_Tag;
    ctl_in.sign     = swap ? sgn2 : sgn1;
    ctl_in.nan      = nan1 | nan2 | (inf1 & inf2 & (sgn1 ^ sgn2));
    ctl_in.inf      = inf1 | inf2;
    ctl_in.inf_sign = inf1 ? sgn1 : sgn2;
    ctl_in.zneg     = zero1 & zero2 & sgn1 & sgn2;
  end

  // S2: align B to A, collecting shifted-out bits into sticky
  logic [EW-1:0] shift_d;
  logic [FW-1:0] b_ext, b_sh, b_align;
  logic          b_sticky;

  always_comb begin
    shift_d  = s1_exp_a - s1_exp_b;
    b_ext    = {s1_man_b, 3'b000};
    b_sh     = b_ext >> shift_d;
    b_sticky = ((b_sh << shift_d) != b_ext);
    b_align  = {b_sh[FW-1:1], b_sh[0] | b_sticky};
  end

  // S3: magnitude add/subtract; A >= B so the difference is non-negative
  logic [SW-1:0] sum_c;

  always_comb begin
    if (s2_eff_sub) sum_c = {1'b0, s2_man_a} - {1'b0, s2_man_b};
    else            sum_c = {1'b0, s2_man_a} + {1'b0, s2_man_b};
  end

  // S4: normalize, round, handle specials and range, pack
  logic [LW-1:0]        lzc;
  logic [FW-1:0]        norm;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [MW:0]          mant;
  logic                 g_bit, r_bit, s_bit, inc;
  logic [RW-1:0]        rnd;
  logic [MW-1:0]        frac;
  logic                 res_sign;
  logic [EW-1:0]        res_exp;
  logic [MW-1:0]        res_frac;
  logic                 f_ovf, f_unf, f_inx, f_inv;

  always_comb begin
    lzc = LW'(FW);
    for (int i = 0; i < int'(FW); i++) begin
      if (s3_sum[i]) lzc = LW'(int'(FW) - 1 - i);
    end

    if (s3_sum[SW-1]) begin
      norm  = {s3_sum[SW-1:2], s3_sum[1] | s3_sum[0]};
      exp_n = signed'(XW'(s3_exp)) + signed'(XW'(1));
    end else begin
      norm  = s3_sum[FW-1:0] << lzc;
      exp_n = signed'(XW'(s3_exp)) - signed'(XW'(lzc));
    end

    mant  = norm[FW-1:3];
    g_bit = norm[2];
    r_bit = norm[1];
    s_bit = norm[0];
`ifdef FPU_ADDSUB_RNE_EN
    inc = g_bit & (r_bit | s_bit | mant[0]);
`else
    inc = 1'b0;
`endif
    rnd = {1'b0, mant} + RW'(inc);
    if (rnd[RW-1]) begin
      exp_r = exp_n + signed'(XW'(1));
      frac  = rnd[MW:1];
    end else begin
      exp_r = exp_n;
      frac  = rnd[MW-1:0];
    end

    res_sign = s3_ctl.sign;
    res_exp  = exp_r[EW-1:0];
    res_frac = frac;
    f_ovf    = 1'b0;
    f_unf    = 1'b0;
    f_inx    = g_bit | r_bit | s_bit;
    f_inv    = 1'b0;

    if (s3_ctl.nan) begin
      res_sign         = 1'b0;
      res_exp          = EXP_ONES;
      res_frac         = '0;
      res_frac[MW-1]   = 1'b1;
      f_inx            = 1'b0;
      f_inv            = 1'b1;
    end else if (s3_ctl.inf) begin
      res_sign = s3_ctl.inf_sign;
      res_exp  = EXP_ONES;
      res_frac = '0;
      f_inx    = 1'b0;
    end else if (s3_sum == '0) begin
      // Exact cancellation gives +0 except (-0) + (-0)
      res_sign = s3_ctl.zneg;
      res_exp  = '0;
      res_frac = '0;
      f_inx    = 1'b0;
    end else if (exp_r >= signed'(XW'(EXP_ONES))) begin
      f_ovf = 1'b1;
      f_inx = 1'b1;
`ifdef FPU_ADDSUB_RNE_EN
      res_exp  = EXP_ONES;
      res_frac = '0;
`else
      res_exp  = EXP_ONES - EW'(1);
      res_frac = '1;
`endif
    end else if (exp_r < signed'(XW'(1))) begin
      f_unf    = 1'b1;
      f_inx    = 1'b1;
      res_exp  = '0;
      res_frac = '0;
    end
  end

  // Pipeline state: every stage advances together unless stalled
  always_ff @(posedge I_Clk or posedge I_Reset) begin
    if (I_Reset) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      s1_ctl      <= '0;
      s2_ctl      <= '0;
      s3_ctl      <= '0;
      s1_eff_sub  <= 1'b0;
      s2_eff_sub  <= 1'b0;
      s1_exp_a    <= '0;
      s1_exp_b    <= '0;
      s2_exp_a    <= '0;
      s3_exp      <= '0;
      s1_man_a    <= '0;
      s1_man_b    <= '0;
      s2_man_a    <= '0;
      s2_man_b    <= '0;
      s3_sum      <= '0;
      O_Valid     <= 1'b0;
      O_Result    <= '0;
      O_Tag       <= '0;
      O_Overflow  <= 1'b0;
      O_Underflow <= 1'b0;
      O_Inexact   <= 1'b0;
      O_Invalid   <= 1'b0;
    end else if (!stall) begin
      s1_valid    <= I_Valid;
      s1_ctl      <= ctl_in;
      s1_eff_sub  <= sgn1 ^ sgn2;
      s1_exp_a    <= swap ? exp2 : exp1;
      s1_exp_b    <= swap ? exp1 : exp2;
      s1_man_a    <= swap ? man2 : man1;
      s1_man_b    <= swap ? man1 : man2;

      s2_valid    <= s1_valid;
      s2_ctl      <= s1_ctl;
      s2_eff_sub  <= s1_eff_sub;
      s2_exp_a    <= s1_exp_a;
      s2_man_a    <= {s1_man_a, 3'b000};
      s2_man_b    <= b_align;

      s3_valid    <= s2_valid;
      s3_ctl      <= s2_ctl;
      s3_exp      <= s2_exp_a;
      s3_sum      <= sum_c;

      O_Valid     <= s3_valid;
      O_Result    <= {res_sign, res_exp, res_frac};
      O_Tag       <= s3_ctl.tag;
      O_Overflow  <= f_ovf;
      O_Underflow <= f_unf;
      O_Inexact   <= f_inx;
      O_Invalid   <= f_inv;
    end
  end

endmodule

// File: doc/fpu_add_sub_pipe.md
# fpu_add_sub_pipe

Pipelined IEEE-754 adder/subtractor that accepts two packed operands (single or double precision, per PRECISION) and returns a normalized, rounded, packed result. It is the arithmetic back end of the FPU datapath, fed by the fixed-point-to-IEEE normalizers. It generalizes the earlier pre-normalize/add stages: it adds a full result normalize/round/pack stage, special-value handling, status flags, a pass-through tag, and ready/valid backpressure across all four stages.

## Interface
- PRECISION, 32: 32 or 64. Derived: E = 8/11 exponent bits, M = 23/52 fraction bits, bias 127/1023.
- TAG_WIDTH, 4: width of the opaque tag carried alongside each operation.
- I_Clk  in  1  clock; all state updates on its rising edge.
- I_Reset  in  1  reset, asynchronous assert, active-high; clears all valid bits and outputs.
- I_Valid  in  1  input operation valid.
- O_Ready  out  1  block can accept an input this cycle.
- I_Op1  in  PRECISION  packed operand 1.
- I_Op2  in  PRECISION  packed operand 2.
- I_Sub  in  1  0 = Op1+Op2, 1 = Op1−Op2.
- I_Tag  in  TAG_WIDTH  returned unchanged with the result.
- O_Valid  out  1  result valid.
- I_Ready  in  1  downstream accepts result.
- O_Result  out  PRECISION  packed result.
- O_Tag  out  TAG_WIDTH  tag of this result.
- O_Overflow, O_Underflow, O_Inexact, O_Invalid  out  1 each  per-result status flags, qualified by O_Valid.

## Operation
- Four stages, each with its own valid bit. A global stall is active when O_Valid=1 and I_Ready=0; it freezes all stages. O_Ready = !stall, combinational.
- An input transfers when I_Valid & O_Ready. An output transfers when O_Valid & I_Ready.
- S1, unpack/swap:
  - Op2 sign is inverted if I_Sub=1.
  - Exponent 0 is treated as zero; denormals are flushed to zero.
  - Hidden 1 is prepended for nonzero operands.
  - The operand with the larger magnitude (exponent, then fraction) becomes A. Specials are classified here.
- S2, align: B's mantissa is right-shifted by d = expA−expB into an M+4-bit field (hidden bit + M + guard/round/sticky). The sticky bit is the OR of all bits shifted out. If d > M+3, B collapses to sticky only.
- S3, add: effective subtract = signA XOR signB. The sum is M+5 bits including carry. Result sign = signA.
- S4, normalize/round/pack:
  - On carry, shift right 1 (exponent +1, sticky accumulates).
  - Otherwise, leading-zero count and shift left (exponent −lzc).
  - Round, then renormalize if rounding carries out.
- Specials, decided in S1 and carried forward:
  - Any NaN input, or inf−inf (effective subtract), gives canonical quiet NaN (exponent all-ones, fraction MSB=1, sign 0) with O_Invalid=1.
  - Otherwise, an inf input gives that inf.
- Exact zero result is +0. The exception is when both operands are zero with sign −: the result is −0.
- Overflow: final exponent ≥ all-ones gives ±inf, O_Overflow=1, O_Inexact=1.
- Underflow: final exponent ≤ 0 with a nonzero result gives signed zero, O_Underflow=1, O_Inexact=1.
- O_Inexact=1 whenever any of guard/round/sticky is nonzero before rounding.

## Timing
- Latency is 4 cycles from input transfer to O_Valid with no stall. Throughput is 1 per cycle.
- Reset values: O_Valid=0, O_Result=0, O_Tag=0, all flags 0, all stage valids 0. O_Ready=1 during and after reset.
- Reset asserted mid-operation discards all in-flight operations. No result is emitted for them.
- A stall holds O_Result, O_Tag and the flags stable until transfer. Stage data registers load only when not stalled.
- Bubbles are not squeezed. Backpressure is all-or-nothing.
- I_Valid=1 while O_Ready=0: the input is not taken. The source holds it.
- Simultaneous output transfer and input transfer in the same cycle is allowed.

## Configuration
- FPU_ADDSUB_RNE_EN defined: round-to-nearest-even. Increment if G & (R | S | LSB).
- Macro undefined: round toward zero (truncation). O_Inexact is still reported. Overflow in this mode gives the max finite value instead of inf, and O_Overflow=1.

## Test plan
- PRECISION=32, 0x3F800000 + 0x40000000, I_Sub=0, tag 5 → after 4 cycles O_Result=0x40400000, O_Tag=5, all flags 0.
- 0x3F800000 − 0x3F800000 → 0x00000000, flags 0. Also 0x80000000 + 0x80000000 → 0x80000000.
- 0x3F800000 + 0x33C00000 → RNE build 0x3F800001, truncation build 0x3F800000. Both builds O_Inexact=1. Tie case 0x3F800000 + 0x33800000 → 0x3F800000 in both builds.
- 0x7F7FFFFF + 0x7F7FFFFF → RNE 0x7F800000, truncation 0x7F7FFFFF. O_Overflow=1. Also 0x7F800000 − 0x7F800000 → 0x7FC00000 with O_Invalid=1.
- Back-to-back 8 operations with I_Ready held low for cycles 5–7:
  - O_Ready=0 and O_Result stable while stalled.
  - All 8 results appear in order with matching tags; none lost or duplicated.
- Reset pulse with 3 operations in flight → O_Valid=0 immediately. No stale result after reset release. The next input yields a correct result 4 cycles later.
